// File: rtl/trig_generator.sv
// Trigger register decoder: turns bus writes to TRIG_ADDR into one-cycle
// clear strobes for the I2S-in overrun and I2S-out underrun flags.
module trig_generator #(
  parameter logic [10:0] TRIG_ADDR    = 11'h00C,
  parameter int unsigned I2SI_OVR_BIT = 0,
  parameter int unsigned I2SO_UND_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] address,
  input  logic [7:0]  wdata,
  input  logic        xfc,
  output logic        trig_i2si_fifo_overrun_clr,
  output logic        trig_i2so_fifo_underrun_clr
);

  logic hit;

  // Full 11-bit compare so that no other address aliases onto the trigger.
  always_comb begin
    hit = xfc && (address == TRIG_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_i2si_fifo_overrun_clr  <= 1'b0;
      trig_i2so_fifo_underrun_clr <= 1'b0;
    end else begin
      trig_i2si_fifo_overrun_clr  <= hit & wdata[I2SI_OVR_BIT];
      trig_i2so_fifo_underrun_clr <= hit & wdata[I2SO_UND_BIT];
    end
  end

endmodule

// File: tb/tb_trig_generator.sv
// Scoreboard bench for trig_generator: directed plan plus random writes,
// expected strobes queued at drive time and checked after each clock edge.
module tb_trig_generator;

  logic        clk;
  logic        rst_n;
  logic [10:0] address;
  logic [7:0]  wdata;
  logic        xfc;
  logic        ovr_clr;
  logic        und_clr;

  int errors = 0;
  int checks = 0;

  // Each entry is {underrun_clr, overrun_clr} expected after the next edge.
  logic [1:0] exp_q[$];

  trig_generator #(
    .TRIG_ADDR   (11'h00C),
    .I2SI_OVR_BIT(0),
    .I2SO_UND_BIT(1)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .address                    (address),
    .wdata                      (wdata),
    .xfc                        (xfc),
    .trig_i2si_fifo_overrun_clr (ovr_clr),
    .trig_i2so_fifo_underrun_clr(und_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got und/ovr=%b required=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural reference: a write to register 0x00C requests the clears
  // named by bits 0 and 1; reset or no write requests nothing.
  function automatic logic [1:0] model(input logic rst, input logic x,
                                       input logic [10:0] a, input logic [7:0] d);
    logic [1:0] r;
    r = 2'b00;
    if (rst && x && a == 11'd12) begin
      r[0] = d[0];
      r[1] = d[1];
    end
    return r;
  endfunction

  // Drive one bus cycle at the falling edge and queue its expected response.
  task automatic drive(input logic rst, input logic x, input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    rst_n   = rst;
    xfc     = x;
    address = a;
    wdata   = d;
    exp_q.push_back(model(rst, x, a, d));
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    logic [1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("scoreboard", {und_clr, ovr_clr}, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    xfc     = 1'b1;
    address = 11'h00C;
    wdata   = 8'h03;
    #1;
    check("reset_immediate", {und_clr, ovr_clr}, 2'b00);

    // Reset held with a qualifying write on the bus
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 11'h00C, 8'h03);
    drive(1'b1, 1'b1, 11'h00C, 8'h03);
    drive(1'b1, 1'b0, 11'h00C, 8'h03);

    // Single writes
    drive(1'b1, 1'b1, 11'h00C, 8'h01);
    drive(1'b1, 1'b0, 11'h000, 8'h00);
    drive(1'b1, 1'b1, 11'h00C, 8'h02);
    drive(1'b1, 1'b0, 11'h000, 8'h00);
    drive(1'b1, 1'b1, 11'h00C, 8'h03);
    drive(1'b1, 1'b0, 11'h000, 8'h00);
    drive(1'b1, 1'b1, 11'h00C, 8'hFC);
    drive(1'b1, 1'b0, 11'h000, 8'h00);

    // Back-to-back sweep
    for (int unsigned v = 0; v <= 32; v++) drive(1'b1, 1'b1, 11'h00C, 8'(v));
    drive(1'b1, 1'b0, 11'h00C, 8'h03);
    drive(1'b1, 1'b0, 11'h00C, 8'h03);

    // Decode misses
    drive(1'b1, 1'b1, 11'h00D, 8'h03);
    drive(1'b1, 1'b1, 11'h40C, 8'h03);
    drive(1'b1, 1'b1, 11'h000, 8'h03);
    drive(1'b1, 1'b0, 11'h00C, 8'h03);

    // Async reset mid-pulse
    drive(1'b1, 1'b1, 11'h00C, 8'h01);
    @(posedge clk);
    #3;
    check("pulse_before_reset", {und_clr, ovr_clr}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {und_clr, ovr_clr}, 2'b00);
    drive(1'b0, 1'b1, 11'h00C, 8'h03);
    drive(1'b1, 1'b0, 11'h00C, 8'h00);

    // Random traffic, biased toward the trigger address
    for (int i = 0; i < 300; i++) begin
      logic [10:0] a;
      logic        r;
      case ($urandom_range(0, 3))
        0:       a = 11'($urandom);
        1:       a = 11'h00C ^ (11'd1 << $urandom_range(0, 10));
        default: a = 11'h00C;
      endcase
      r = ($urandom_range(0, 39) != 0);
      drive(r, 1'($urandom), a, 8'($urandom));
    end

    drive(1'b1, 1'b0, 11'h000, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trig_generator.md
Name: trig_generator

Overview:
- Register-bus trigger decoder. Watches the peripheral write bus (address, wdata, xfc) for writes to the I2S trigger register.
- Converts selected data bits into single-cycle clear strobes for the I2S input-FIFO overrun flag and the I2S output-FIFO underrun flag.
- Sits between the bus slave interface and the I2S status logic.

Parameters:
- TRIG_ADDR, 11'h00C, register address that is decoded as the trigger register.
- I2SI_OVR_BIT, 0, wdata bit index that requests the I2S-in FIFO overrun clear.
- I2SO_UND_BIT, 1, wdata bit index that requests the I2S-out FIFO underrun clear.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  11  bus register address, qualified by xfc.
- wdata  input  8  bus write data, qualified by xfc.
- xfc  input  1  write transfer-complete strobe; one write per cycle in which it is high.
- trig_i2si_fifo_overrun_clr  output  1  one-cycle clear pulse for the I2S-in overrun flag.
- trig_i2so_fifo_underrun_clr  output  1  one-cycle clear pulse for the I2S-out underrun flag.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset: while rst_n=0, both outputs are 0 immediately, without waiting for a clock edge. The first trigger can be captured at the first rising edge after rst_n goes high.
- Write hit: hit = xfc & (address == TRIG_ADDR). The compare uses all 11 bits, with no aliasing.
- Outputs are registered and update at every rising edge of clk:
  - trig_i2si_fifo_overrun_clr <= hit & wdata[I2SI_OVR_BIT]
  - trig_i2so_fifo_underrun_clr <= hit & wdata[I2SO_UND_BIT]
- Latency: a pulse is high for exactly the one cycle after the edge where hit was sampled.
- Outputs are never held high. Each output returns to 0 on the next edge unless that edge samples another qualifying write.
- Back-to-back writes: if xfc stays high for N consecutive cycles at TRIG_ADDR, each cycle is treated as an independent write. The output follows the per-cycle bit value, delayed by one cycle, and can stay high for several cycles if the bit stays 1.
- Both bits set in one write produce both pulses in the same cycle.
- Other wdata bits are ignored, and wdata is ignored when there is no hit.
- xfc=0 means no pulse, whatever address and wdata are.
- Reset mid-pulse: an asserted output drops immediately, and the write in flight is discarded.
- No internal state beyond the two output flops. No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles with xfc=1, address=0x00C, wdata=0x03 -> both outputs stay 0. Release reset -> both pulse from the first post-reset edge.
- Single write: address=0x00C, wdata=0x01, xfc high for 1 cycle -> overrun_clr=1 for exactly 1 cycle, starting one edge later. underrun_clr stays 0.
- Single write: wdata=0x02 -> only underrun_clr pulses. wdata=0x03 -> both pulse in the same cycle. wdata=0xFC -> neither pulses.
- Sweep: address=0x00C, xfc held high while wdata increments 0x00..0x20 each cycle, then xfc=0. Each output equals the previous cycle's wdata bit 0 (overrun) or bit 1 (underrun). Both are 0 once xfc drops.
- Decode miss: wdata=0x03, xfc=1 with address=0x00D, 0x40C and 0x000 -> no pulses. address=0x00C with xfc=0 -> no pulses.
- Async reset mid-pulse: assert rst_n=0 between clock edges while overrun_clr=1 -> output falls to 0 before the next clk edge.
